// File: rtl/axis_flatten.sv
// axis_flatten: repacks a sparse AXI Stream so every output beat is full except the last of a packet.
// A 2W-byte buffer collects input bytes; beats leave once strictly more than W bytes are held or on tlast.
module axis_flatten #(
  parameter int unsigned TDATA_WIDTH = 256,
  parameter int unsigned TUSER_WIDTH = 128,
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic [TDATA_WIDTH-1:0] axis_sparse_tdata,
  input  logic [TKEEP_WIDTH-1:0] axis_sparse_tkeep,
  input  logic [TUSER_WIDTH-1:0] axis_sparse_tuser,
  input  logic                   axis_sparse_tvalid,
  output logic                   axis_sparse_tready,
  input  logic                   axis_sparse_tlast,
  output logic [TDATA_WIDTH-1:0] axis_packed_tdata,
  output logic [TKEEP_WIDTH-1:0] axis_packed_tkeep,
  output logic [TUSER_WIDTH-1:0] axis_packed_tuser,
  output logic                   axis_packed_tvalid,
  input  logic                   axis_packed_tready,
  output logic                   axis_packed_tlast
);

  localparam int unsigned KW = TKEEP_WIDTH;
  localparam int unsigned CW = $clog2(2 * KW + 1);
  localparam int unsigned BW = 2 * TDATA_WIDTH;

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          buf_q, buf_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic [TUSER_WIDTH-1:0] user_q, user_d;
  logic                   in_ready_q, in_ready_d;
  logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TKEEP_WIDTH-1:0] out_keep_q, out_keep_d;
  logic [TUSER_WIDTH-1:0] out_user_q, out_user_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;

  logic                   accept, out_free, flushing;
  logic [CW-1:0]          n, total;
  logic [TDATA_WIDTH-1:0] in_masked;
  logic [BW-1:0]          app;
  logic [TUSER_WIDTH-1:0] user_cur;

  // Next-state: append the accepted beat, then emit a full or final beat if the output slot allows.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    user_d      = user_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    in_ready_d  = 1'b0;
    n           = '0;
    in_masked   = '0;

    accept   = axis_sparse_tvalid & in_ready_q;
    out_free = ~out_valid_q | axis_packed_tready;

    if (accept) begin
      for (int i = 0; i < KW; i++) begin
        n = n + CW'(axis_sparse_tkeep[i]);
        in_masked[8*i +: 8] = axis_sparse_tdata[8*i +: 8] & {8{axis_sparse_tkeep[i]}};
      end
    end

    // Bytes above cnt_q are always zero, so OR-ing in the shifted beat appends it.
    app      = buf_q | ({{TDATA_WIDTH{1'b0}}, in_masked} << {cnt_q, 3'b000});
    total    = cnt_q + n;
    flushing = (state_q == FLUSH) | (accept & axis_sparse_tlast);
    user_cur = (accept & first_q) ? axis_sparse_tuser : user_q;

    if (accept) begin
      first_d = axis_sparse_tlast;
      if (first_q) user_d = axis_sparse_tuser;
    end

    if (out_valid_q & axis_packed_tready) out_valid_d = 1'b0;

    buf_d   = app;
    cnt_d   = total;
    state_d = flushing ? FLUSH : ACCUM;

    if (out_free && total > CW'(KW)) begin
      out_data_d  = app[TDATA_WIDTH-1:0];
      out_keep_d  = '1;
      out_user_d  = user_cur;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      buf_d       = app >> TDATA_WIDTH;
      cnt_d       = total - CW'(KW);
    end else if (out_free && flushing) begin
      out_data_d  = app[TDATA_WIDTH-1:0];
      for (int i = 0; i < KW; i++) out_keep_d[i] = (CW'(i) < total);
      out_user_d  = user_cur;
      out_last_d  = 1'b1;
      out_valid_d = 1'b1;
      buf_d       = '0;
      cnt_d       = '0;
      state_d     = ACCUM;
    end

    // Registered ready: only offered while a whole W-byte beat is guaranteed to fit.
    in_ready_d = (state_d == ACCUM) && (cnt_d <= CW'(KW));
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q     <= ACCUM;
      buf_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      user_q      <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      user_q      <= user_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign axis_sparse_tready = in_ready_q;
  assign axis_packed_tdata  = out_data_q;
  assign axis_packed_tkeep  = out_keep_q;
  assign axis_packed_tuser  = out_user_q;
  assign axis_packed_tlast  = out_last_q;
  assign axis_packed_tvalid = out_valid_q;

endmodule

// File: doc/axis_flatten.md
Name: axis_flatten

Overview:
- Repacks an AXI Stream whose beats may be partially filled into a flattened stream, so downstream stages receive full beats.
- Every output beat except the last of a packet carries TKEEP_WIDTH bytes.
- Sits directly downstream of axis_trim_front, whose first output beat per packet is short. It also sits upstream of any stage that requires flattened input.
- Byte order within the packet is preserved: lowest byte lane first, lower beats first.

Parameters:
- TDATA_WIDTH, 256, data bus width in bits; a multiple of 8.
- TUSER_WIDTH, 128, sideband width in bits.
- TKEEP_WIDTH (localparam), TDATA_WIDTH/8, bytes per beat; referred to below as W.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  synchronous active-low reset.
- axis_sparse_tdata  in  TDATA_WIDTH  input data.
- axis_sparse_tkeep  in  TKEEP_WIDTH  input byte enables; contiguous from bit 0 (low-justified), may be all zero.
- axis_sparse_tuser  in  TUSER_WIDTH  input sideband.
- axis_sparse_tvalid  in  1  input valid.
- axis_sparse_tready  out  1  input ready.
- axis_sparse_tlast  in  1  end of input packet.
- axis_packed_tdata  out  TDATA_WIDTH  packed data.
- axis_packed_tkeep  out  TKEEP_WIDTH  packed byte enables, low-justified.
- axis_packed_tuser  out  TUSER_WIDTH  sideband.
- axis_packed_tvalid  out  1  output valid.
- axis_packed_tready  in  1  output ready.
- axis_packed_tlast  out  1  end of output packet.

Behaviour:
- Clock and reset: one clock, axis_aclk. Reset is synchronous and active-low on axis_resetn.
- Reset values: all outputs 0 (tvalid, tdata, tkeep, tuser, tlast). The byte buffer count is 0, the state is ACCUM, and the tuser latch is cleared. Reset mid-packet drops all buffered bytes; the next accepted beat is treated as the start of a packet.
- Byte buffer:
  - Holds 2W bytes plus a byte count cnt in the range 0..2W.
  - An accepted input beat contributes n = popcount(tkeep) bytes, appended at buffer offset cnt.
  - A non-contiguous tkeep is a protocol error; the block does not check it.
- Handshakes:
  - Input transfer: tvalid & tready. Output transfer: tvalid & tready.
  - Standard AXI-Stream rules: the output holds tdata, tkeep, tuser and tlast stable while tvalid=1 and tready=0.
  - Output is driven from registers; there is no combinational path from input to output or from axis_packed_tready to axis_sparse_tready.
- State ACCUM:
  - axis_sparse_tready = (cnt <= W) after accounting for an output beat leaving in the current cycle, i.e. room for a full W-byte beat is guaranteed.
  - When cnt > W and the output register is free (or freeing this cycle), load the lowest W bytes into the output: tkeep all ones, tlast 0. Shift the buffer down by W bytes.
  - A beat is held back until strictly more than W bytes are present. This guarantees a later byte exists, so the beat cannot be the last one.
  - On acceptance of a beat with tlast=1, go to FLUSH.
- State FLUSH:
  - axis_sparse_tready = 0.
  - Emit the buffer as ceil(cnt/W) beats: full beats first, then the final beat with tkeep = (1<<(cnt mod W))-1, or all ones if the remainder is 0. tlast=1 on the final beat only.
  - Zero-length packet (cnt=0 at tlast): emit exactly one beat with tkeep=0, tlast=1.
  - After the last beat transfers, cnt=0 and the state returns to ACCUM. The input may be accepted in that same cycle.
- tuser: latched from the first accepted input beat of each packet, and driven on every output beat of that packet.
- Throughput and latency:
  - Full-width input sustains 1 beat per cycle after the first beat, with tready held high.
  - An output beat is valid 1 cycle after the input transfer that makes it emittable.
  - Packets are never merged: bytes from packet N+1 are not placed into packet N's beats.
- Output backpressure: input stalls only when the buffer cannot take W more bytes. Buffered bytes are never overwritten.
- Data lanes outside tkeep on output: 0.

Test Plan:
- W=32. Packet beats: keep 0x0003FFFF (18 bytes, data bytes 0..17) then 0xFFFFFFFF with tlast (bytes 18..49) -> two output beats: bytes 0..31 with keep 0xFFFFFFFF, tlast=0; then bytes 32..49 with keep 0x0003FFFF, tlast=1.
- Packet of 3 full beats -> 3 full output beats, tlast on the third; tready stays high; 1 output beat per cycle once streaming.
- Packet of 20-byte beat, then a keep=0 beat with tlast -> one beat: keep 0x000FFFFF, tlast=1.
- A single keep=0 beat with tlast -> one output beat: keep=0, tlast=1, tuser equal to the input tuser.
- axis_packed_tready held 0 for 10 cycles mid-packet -> output holds stable; tready drops when cnt > W; no byte lost or duplicated, checked against the reference byte queue.
- Reset asserted for 1 cycle mid-packet (cnt=18) -> tvalid=0 next cycle; the next packet is output with no stale bytes.
